fifo_stream_reader: RTL and testbench

- Reader-side companion to the team's push/pop FIFO.
- Drains a FIFO's pop interface (empty/pop/data, configurable read latency) and presents the data as a registered valid/ready stream.
- Uses a small credit-controlled output buffer, so no popped word is ever lost.
- Breaks all combinational paths between the FIFO's pop side and the downstream consumer.

---
 rtl/fifo_stream_reader_if.sv | 24 ++
 rtl/fifo_stream_reader.sv | 124 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Pop side of an upstream FIFO plus the registered valid/ready stream it feeds.
// master = the reader (drives pop and the stream); slave = FIFO + consumer.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 2
);
  logic                  fifo_empty_i;
  logic                  fifo_pop_o;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic [CNT_WIDTH-1:0]  usage_o;

  modport master (
    input  fifo_empty_i, fifo_data_i, ready_i,
    output fifo_pop_o, valid_o, data_o, usage_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, ready_i,
    input  fifo_pop_o, valid_o, data_o, usage_o
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO pop port into a credit-checked buffer; valid_o follows a pop by READ_LATENCY+1 cycles.
// Pops stop once buffered + in-flight words fill the buffer; ready_i never reaches fifo_pop_o.
module fifo_stream_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 0,
  parameter int BUF_DEPTH    = 2,
  parameter int CNT_WIDTH    = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  fifo_stream_reader_if.master bus
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SUM_W = CNT_WIDTH + 2;

  if (READ_LATENCY < 0 || READ_LATENCY > 2) begin : g_bad_latency
    $error("fifo_stream_reader: READ_LATENCY must be 0..2");
  end
  if (BUF_DEPTH < 1) begin : g_bad_depth
    $error("fifo_stream_reader: BUF_DEPTH must be >= 1");
  end
  if (CNT_WIDTH != $clog2(BUF_DEPTH + 1)) begin : g_bad_cnt
    $error("fifo_stream_reader: CNT_WIDTH is derived and must not be overridden");
  end

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      wptr_q;
  logic [PTR_W-1:0]      rptr_q;
  logic [CNT_WIDTH-1:0]  buf_cnt_q;
  logic [CNT_WIDTH-1:0]  buf_cnt_n;
  logic [SUM_W-1:0]      inflight;
  logic                  pop;
  logic                  capture;
  logic                  deq;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit counts words already returning, so capture can never find the buffer full.
  assign pop = ~bus.fifo_empty_i & ~flush_i &
               ((SUM_W'(buf_cnt_q) + inflight) < SUM_W'(BUF_DEPTH));

  if (READ_LATENCY == 0) begin : g_no_pipe
    assign inflight = '0;
    assign capture  = pop;
  end else begin : g_pipe
    logic [READ_LATENCY-1:0] pipe_q;
    logic [READ_LATENCY-1:0] pipe_n;

    always_comb begin
      pipe_n    = pipe_q;
      pipe_n[0] = pop;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_n[i] = pipe_q[i-1];
      end
    end

    always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        inflight = inflight + SUM_W'(pipe_q[i]);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_q <= '0;
      end else if (flush_i) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_n;
      end
    end

    // Reads issued before a flush land during it and are dropped.
    assign capture = pipe_q[READ_LATENCY-1] & ~flush_i;
  end

  assign deq       = bus.valid_o & bus.ready_i;
  assign buf_cnt_n = buf_cnt_q + CNT_WIDTH'(capture) - CNT_WIDTH'(deq);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      buf_cnt_q <= '0;
    end else if (flush_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      buf_cnt_q <= '0;
    end else begin
      if (capture) wptr_q <= next_ptr(wptr_q);
      if (deq)     rptr_q <= next_ptr(rptr_q);
      buf_cnt_q <= buf_cnt_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (capture) begin
      mem_q[wptr_q] <= bus.fifo_data_i;
    end
  end

  assign bus.fifo_pop_o = pop;
  assign bus.valid_o    = (buf_cnt_q != '0);
  assign bus.data_o     = mem_q[rptr_q];
  assign bus.usage_o    = buf_cnt_q;

  a_no_pop_when_empty: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(bus.fifo_pop_o && bus.fifo_empty_i));

  a_no_capture_when_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(capture && buf_cnt_q == CNT_WIDTH'(BUF_DEPTH)));

  a_stream_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (bus.valid_o && !bus.ready_i && !flush_i) |=> (bus.valid_o && $stable(bus.data_o)));
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Four reader configurations, each fed by a behavioural FIFO with a matching read latency.
// Directed steps in one initial block; words not popped survive reset in the FIFO model.
module tb_fifo_stream_reader;
  localparam int N = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        rdy   [N];
  logic        fl    [N];
  logic        hold  [N];
  int          tail  [N];
  logic [31:0] mem   [N][2048];
  logic        vld_w [N];
  logic        pop_w [N];
  logic [31:0] dat_w [N];
  logic [2:0]  use_w [N];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // inst0: lat0/depth2, inst1: lat1/depth3, inst2: lat2/depth4, inst3: lat1/depth2
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 0 : (g == 2) ? 2 : 1;
    localparam int DEP = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 4 : 2;
    localparam int CW  = $clog2(DEP + 1);

    int          head = 0;
    logic [31:0] d1;
    logic [31:0] d2;

    fifo_stream_reader_if #(.DATA_WIDTH(32), .CNT_WIDTH(CW)) bus ();

    fifo_stream_reader #(
      .DATA_WIDTH  (32),
      .READ_LATENCY(LAT),
      .BUF_DEPTH   (DEP)
    ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .flush_i(fl[g]),
      .bus    (bus)
    );

    assign bus.fifo_empty_i = !rst_n || hold[g] || (head == tail[g]);
    assign bus.fifo_data_i  = (LAT == 0) ? mem[g][head] : (LAT == 1) ? d1 : d2;
    assign bus.ready_i      = rdy[g];
    assign vld_w[g]         = bus.valid_o;
    assign pop_w[g]         = bus.fifo_pop_o;
    assign dat_w[g]         = bus.data_o;
    assign use_w[g]         = 3'(bus.usage_o);

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d1 <= '0;
        d2 <= '0;
      end else begin
        d1 <= bus.fifo_pop_o ? mem[g][head] : 32'hDEAD_BEEF;
        d2 <= d1;
        if (fl[g])                head <= tail[g];
        else if (bus.fifo_pop_o)  head <= head + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          npop;
    int          idx;
    int          maxu;
    int          w;
    int          k;
    logic [10:0] pat;

    for (int g = 0; g < N; g++) begin
      rdy[g] = 1'b0; fl[g] = 1'b0; hold[g] = 1'b0; tail[g] = 0;
    end
    for (int i = 0; i < 8; i++)    mem[0][i]      = 32'h11 + 32'(i);
    for (int i = 0; i < 6; i++)    mem[0][8 + i]  = 32'h51 + 32'(i);
    for (int i = 0; i < 10; i++)   mem[1][i]      = 32'hA0 + 32'(i);
    for (int i = 0; i < 6; i++)    mem[3][i]      = 32'hC0 + 32'(i);
    for (int i = 0; i < 1000; i++) mem[2][i]      = $urandom;
    for (int i = 0; i < 4; i++)    mem[2][1000+i] = 32'hF0 + 32'(i);
    mem[2][1004] = 32'hE0;
    mem[2][1005] = 32'hE1;
    tail[0] = 8;
    rdy[0]  = 1'b1;

    #1 rst_n = 1'b0;
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check("reset_valid", 32'(vld_w[g]), 32'h0);
      check("reset_usage", 32'(use_w[g]), 32'h0);
      check("reset_data",  dat_w[g],      32'h0);
      check("reset_pop",   32'(pop_w[g]), 32'h0);
    end

    // Stream: lat0/depth2, ready held high
    rst_n = 1'b1;
    #1 check("stream_pop", 32'(pop_w[0]), 32'h1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("stream_valid", 32'(vld_w[0]), 32'h1);
      check("stream_data",  dat_w[0],      32'h10 + 32'(c));
      check("stream_usage", 32'(use_w[0]), 32'h1);
      check("stream_pop",   32'(pop_w[0]), (c < 8) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    check("stream_idle", 32'(vld_w[0]), 32'h0);

    // Stall: lat1/depth3, ready low until the buffer fills
    tail[1] = 10;
    #1 npop = 0;
    for (int c = 0; c < 6; c++) begin
      npop += int'(pop_w[1]);
      @(negedge clk);
    end
    check("stall_pops",  32'(npop),      32'd3);
    check("stall_usage", 32'(use_w[1]),  32'd3);
    check("stall_valid", 32'(vld_w[1]),  32'h1);
    check("stall_data",  dat_w[1],       32'hA0);
    repeat (3) @(negedge clk);
    check("stall_hold",  dat_w[1],       32'hA0);
    check("stall_nopop", 32'(pop_w[1]),  32'h0);
    rdy[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("drain_valid", 32'(vld_w[1]), 32'h1);
      check("drain_data",  dat_w[1],      32'hA0 + 32'(c));
      @(negedge clk);
    end
    check("drain_idle", 32'(vld_w[1]), 32'h0);

    // Throughput limit: lat1/depth2 stalls the pop every third cycle
    tail[3] = 6;
    rdy[3]  = 1'b1;
    pat     = 11'b01101101100;
    w       = 0;
    for (int c = 0; c < 11; c++) begin
      check("thru_valid", 32'(vld_w[3]), 32'(pat[c]));
      if (pat[c]) begin
        check("thru_data", dat_w[3], 32'hC0 + 32'(w));
        w++;
      end
      @(negedge clk);
    end

    // Random backpressure and FIFO gaps: lat2/depth4
    tail[2] = 1000;
    idx     = 0;
    maxu    = 0;
    for (int c = 0; c < 20000 && idx < 1000; c++) begin
      rdy[2]  = 1'($urandom_range(0, 1));
      hold[2] = ($urandom_range(0, 3) == 0);
      if (int'(use_w[2]) > maxu) maxu = int'(use_w[2]);
      if (vld_w[2] && rdy[2]) begin
        check("rand_word", dat_w[2], mem[2][idx]);
        idx++;
      end
      @(negedge clk);
    end
    rdy[2]  = 1'b0;
    hold[2] = 1'b0;
    check("rand_count",  32'(idx),         32'd1000);
    check("rand_maxuse", 32'(maxu <= 4),   32'h1);
    @(negedge clk);

    // Flush with two words buffered and two reads in flight
    tail[2] = 1004;
    repeat (4) @(negedge clk);
    check("preflush_usage", 32'(use_w[2]), 32'd2);
    check("preflush_data",  dat_w[2],      32'hF0);
    fl[2] = 1'b1;
    check("flush_pop", 32'(pop_w[2]), 32'h0);
    @(negedge clk);
    fl[2] = 1'b0;
    check("flush_valid", 32'(vld_w[2]), 32'h0);
    check("flush_usage", 32'(use_w[2]), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("flush_drop", 32'(vld_w[2]), 32'h0);
    end
    tail[2] = 1006;
    rdy[2]  = 1'b1;
    k = 0;
    while (!vld_w[2] && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("postflush_valid", 32'(vld_w[2]), 32'h1);
    check("postflush_data0", dat_w[2],      32'hE0);
    @(negedge clk);
    check("postflush_data1", dat_w[2],      32'hE1);

    // Asynchronous reset with two words buffered
    rdy[0]  = 1'b0;
    tail[0] = 14;
    repeat (2) @(negedge clk);
    check("prerst_usage", 32'(use_w[0]), 32'd2);
    check("prerst_data",  dat_w[0],      32'h51);
    rdy[0] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(vld_w[0]), 32'h0);
    check("arst_data",  dat_w[0],      32'h0);
    check("arst_usage", 32'(use_w[0]), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("resume_pop", 32'(pop_w[0]), 32'h1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("resume_valid", 32'(vld_w[0]), 32'h1);
      check("resume_data",  dat_w[0],      32'h53 + 32'(c));
    end
    @(negedge clk);
    check("resume_idle", 32'(vld_w[0]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
